// File: rtl/score_keeper_if.sv
// score_keeper_if: game inputs and renderer-facing outputs of the score keeper.
// The game logic drives the event inputs; the renderer only reads the outputs.
interface score_keeper_if #(
    parameter int NUM_DIGITS = 9
);
    logic                    score_inc;
    logic                    hit;
    logic                    restart;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [2:0]              hearts;
    logic [1:0]              lives;
    logic                    game_over;
    logic                    busy;
    logic                    saturated;

    modport master (
        output score_inc, hit, restart,
        input  digits, hearts, lives, game_over, busy, saturated
    );

    modport slave (
        input  score_inc, hit, restart,
        output digits, hearts, lives, game_over, busy, saturated
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: BCD score accumulator (one digit rippled per clock) plus a
// lives tracker with a post-hit invulnerability window and game-over flag.
// Every output comes straight from a register so the renderer sees stable values.
module score_keeper #(
    parameter int NUM_DIGITS    = 9,
    parameter int LIVES_INIT    = 3,
    parameter int PEND_W        = 4,
    parameter int INVULN_CYCLES = 1_000_000
) (
    input  logic             Clk,
    input  logic             Reset,
    score_keeper_if.slave    bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int INV_W = $clog2(INVULN_CYCLES + 1);

    localparam logic [INV_W-1:0]  INV_LOAD   = INV_W'(INVULN_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [1:0]        LIVES_RST  = 2'(LIVES_INIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_INC  = 1'b1;

    // Thermometer mask of hearts to draw for a given life count.
    function automatic logic [2:0] hearts_of(input logic [1:0] n);
        case (n)
            2'd0:    hearts_of = 3'b000;
            2'd1:    hearts_of = 3'b001;
            2'd2:    hearts_of = 3'b011;
            default: hearts_of = 3'b111;
        endcase
    endfunction

    logic [3:0]        r_dig [NUM_DIGITS];
    logic [IDX_W-1:0]  r_idx;
    logic [0:0]        r_state;
    logic [PEND_W-1:0] r_pend;
    logic              r_busy;
    logic              r_sat;
    logic [INV_W-1:0]  r_inv;
    logic [1:0]        r_lives;
    logic [2:0]        r_hearts;
    logic              r_go;

    logic                    w_all_nines;
    logic                    w_accept;
    logic                    w_inc_ok;
    logic                    w_hit_ok;
    logic                    w_fatal;
    logic [1:0]              w_lives_nx;
    logic [PEND_W-1:0]       w_pend_nx;
    logic [0:0]              w_state_nx;
    logic [3:0]              w_cur;
    logic [4*NUM_DIGITS-1:0] w_digits;

    assign w_accept   = (r_state == S_IDLE) && (r_pend != '0) && !r_go;
    assign w_inc_ok   = bus.score_inc && !r_go;
    assign w_hit_ok   = bus.hit && (r_inv == '0) && (r_lives != 2'd0);
    // A hit that takes the last life also wipes any queued score increments.
    assign w_fatal    = w_hit_ok && (r_lives == 2'd1);
    assign w_lives_nx = w_hit_ok ? r_lives - 2'd1 : r_lives;
    assign w_cur      = r_dig[r_idx];

    // Detect the all-nines score, which cannot be incremented any further.
    always_comb begin
        w_all_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig[i] != 4'd9) w_all_nines = 1'b0;
        end
    end

    // Pending increments: +1 per accepted pulse, -1 per IDLE accept, clamped at max.
    always_comb begin
        w_pend_nx = r_pend;
        if (w_fatal) begin
            w_pend_nx = '0;
        end else if (w_inc_ok && !w_accept) begin
            if (r_pend != PEND_MAX) w_pend_nx = r_pend + 1'b1;
        end else if (!w_inc_ok && w_accept) begin
            w_pend_nx = r_pend - 1'b1;
        end
    end

    // Next FSM state: IDLE starts a ripple, INC ends when a digit absorbs the carry.
    always_comb begin
        w_state_nx = r_state;
        if (r_state == S_IDLE) begin
            if (w_accept && !w_all_nines) w_state_nx = S_INC;
        end else begin
            if (w_cur != 4'd9) w_state_nx = S_IDLE;
        end
    end

    // Score path: pending counter, ripple FSM, digit registers and sticky saturation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
            r_idx   <= '0;
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
        end else if (bus.restart) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
            r_idx   <= '0;
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_pend  <= w_pend_nx;
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == S_INC) || (w_pend_nx != '0);
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (w_all_nines) r_sat <= 1'b1;
                    else             r_idx <= '0;
                end
            end else begin
                if (w_cur != 4'd9) begin
                    r_dig[r_idx] <= w_cur + 4'd1;
                end else begin
                    r_dig[r_idx] <= 4'd0;
                    r_idx        <= r_idx + 1'b1;
                end
            end
        end
    end

    // Lives path: accept a hit outside the invulnerability window, then count it down.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lives  <= LIVES_RST;
            r_hearts <= hearts_of(LIVES_RST);
            r_go     <= 1'b0;
            r_inv    <= '0;
        end else if (bus.restart) begin
            r_lives  <= LIVES_RST;
            r_hearts <= hearts_of(LIVES_RST);
            r_go     <= 1'b0;
            r_inv    <= '0;
        end else begin
            r_lives  <= w_lives_nx;
            r_hearts <= hearts_of(w_lives_nx);
            r_go     <= (w_lives_nx == 2'd0);
            if (w_hit_ok)          r_inv <= INV_LOAD;
            else if (r_inv != '0)  r_inv <= r_inv - 1'b1;
        end
    end

    // Flatten the digit registers onto the output bus, digit 0 in the low nibble.
    always_comb begin
        w_digits = '0;
        for (int i = 0; i < NUM_DIGITS; i++) w_digits[4*i +: 4] = r_dig[i];
    end

    assign bus.digits    = w_digits;
    assign bus.hearts    = r_hearts;
    assign bus.lives     = r_lives;
    assign bus.game_over = r_go;
    assign bus.busy      = r_busy;
    assign bus.saturated = r_sat;

endmodule
